// File: rtl/dac_seq_loader.sv
// Byte-command loader for the 8-bit waveform DAC sequencer. It stages tables and config in
// shadow registers, commits them atomically, and drives the set gate. Optional: LOADER_TIMEOUT_EN.
module dac_seq_loader #(
  parameter int DEPTH       = 10,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [DEPTH*8-1:0] up,
  output logic [DEPTH*8-1:0] down,
  output logic [7:0]         up_states,
  output logic [7:0]         down_states,
  output logic [7:0]         idle,
  output logic               en,
  output logic               set,
  output logic               busy,
  output logic               cmd_err
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0] CMD_UP   = 8'h01;
  localparam logic [7:0] CMD_DOWN = 8'h02;
  localparam logic [7:0] CMD_CFG  = 8'h03;
  localparam logic [7:0] CMD_GATE = 8'h04;
  localparam logic [7:0] CMD_ENA  = 8'h05;
  localparam logic [7:0] CMD_TRIG = 8'h06;

  typedef enum logic [1:0] {ST_CMD = 2'd0, ST_PAYLOAD = 2'd1, ST_COMMIT = 2'd2} state_t;
  typedef enum logic [1:0] {G_STOP = 2'd0, G_CONT_HI = 2'd1, G_CONT_LO = 2'd2, G_SHOT = 2'd3} gate_t;

  if (TIMEOUT_CYC < 1 || DEPTH < 1 || DEPTH > 255) begin : g_param_check
    $error("dac_seq_loader: DEPTH must be 1..255 and TIMEOUT_CYC positive");
  end

  state_t             state_r;
  gate_t              gate_r;
  logic [7:0]         cmd_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   last_r;
  logic [7:0]         sh_r [DEPTH];
  logic [DEPTH*8-1:0] up_r, down_r;
  logic [7:0]         up_states_r, down_states_r, idle_r;
  logic [CNT_W-1:0]   h_cfg_r, l_cfg_r, cnt_r, len_r;
  logic               en_r, set_r, busy_r, cmd_err_r, rx_ready_r;
  logic               accept_s, commit_s;

  function automatic logic [IDX_W-1:0] last_idx(input logic [7:0] c);
    case (c)
      CMD_UP, CMD_DOWN: last_idx = IDX_W'(DEPTH - 1);
      CMD_CFG:          last_idx = IDX_W'(2);
      CMD_GATE:         last_idx = IDX_W'(3);
      default:          last_idx = IDX_W'(0);
    endcase
  endfunction

  function automatic logic has_payload(input logic [7:0] c);
    case (c)
      CMD_UP, CMD_DOWN, CMD_CFG, CMD_GATE, CMD_ENA: has_payload = 1'b1;
      default:                                      has_payload = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] clamp_states(input logic [7:0] v);
    if (v == 8'd0)              clamp_states = 8'd1;
    else if (v > 8'(DEPTH))     clamp_states = 8'(DEPTH);
    else                        clamp_states = v;
  endfunction

  function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] v);
    phase_len = (v == '0) ? CNT_W'(1) : v;
  endfunction

  assign accept_s = rx_valid && rx_ready_r;
  assign commit_s = (state_r == ST_COMMIT);

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_r;
  logic            timeout_s;

  assign timeout_s = (state_r == ST_PAYLOAD) && !accept_s && (idle_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // Payload inactivity counter; cleared by every accepted byte and outside PAYLOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= '0;
    end else if (state_r == ST_PAYLOAD && !accept_s && !timeout_s) begin
      idle_cnt_r <= idle_cnt_r + TO_W'(1);
    end else begin
      idle_cnt_r <= '0;
    end
  end
`else
  logic timeout_s;
  assign timeout_s = 1'b0;
`endif

  // Command FSM: decode, shadow capture and the single-cycle atomic commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_CMD;
      cmd_r         <= 8'h00;
      idx_r         <= '0;
      last_r        <= '0;
      rx_ready_r    <= 1'b1;
      busy_r        <= 1'b0;
      cmd_err_r     <= 1'b0;
      up_r          <= '0;
      down_r        <= '0;
      up_states_r   <= 8'd1;
      down_states_r <= 8'd1;
      idle_r        <= 8'h00;
      h_cfg_r       <= '0;
      l_cfg_r       <= '0;
      en_r          <= 1'b0;
      for (int k = 0; k < DEPTH; k++) sh_r[k] <= 8'h00;
    end else begin
      cmd_err_r <= 1'b0;
      case (state_r)
        ST_CMD: begin
          if (accept_s) begin
            cmd_r  <= rx_data;
            idx_r  <= '0;
            last_r <= last_idx(rx_data);
            if (rx_data == CMD_TRIG) begin
              state_r    <= ST_COMMIT;
              rx_ready_r <= 1'b0;
              busy_r     <= 1'b1;
            end else if (has_payload(rx_data)) begin
              state_r <= ST_PAYLOAD;
              busy_r  <= 1'b1;
            end else begin
              cmd_err_r <= 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (accept_s) begin
            sh_r[idx_r] <= rx_data;
            if (idx_r == last_r) begin
              state_r    <= ST_COMMIT;
              rx_ready_r <= 1'b0;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else if (timeout_s) begin
            state_r   <= ST_CMD;
            busy_r    <= 1'b0;
            cmd_err_r <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state_r    <= ST_CMD;
          rx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
          case (cmd_r)
            CMD_UP:   for (int k = 0; k < DEPTH; k++) up_r[8*k +: 8] <= sh_r[k];
            CMD_DOWN: for (int k = 0; k < DEPTH; k++) down_r[8*k +: 8] <= sh_r[k];
            CMD_CFG: begin
              up_states_r   <= clamp_states(sh_r[0]);
              down_states_r <= clamp_states(sh_r[1]);
              idle_r        <= sh_r[2];
            end
            CMD_GATE: begin
              h_cfg_r <= CNT_W'({sh_r[1], sh_r[0]});
              l_cfg_r <= CNT_W'({sh_r[3], sh_r[2]});
            end
            CMD_ENA: en_r <= sh_r[0][0];
            default: ;
          endcase
        end
        default: begin
          state_r    <= ST_CMD;
          rx_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  // Gate generator. Phase length is latched at each phase start, so a new H/L only
  // applies from the next boundary. Any enable commit other than en=1,cont=1 stops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_r <= G_STOP;
      set_r  <= 1'b0;
      cnt_r  <= '0;
      len_r  <= CNT_W'(1);
    end else if (commit_s && cmd_r == CMD_ENA) begin
      cnt_r <= '0;
      if (sh_r[0][1:0] == 2'b11) begin
        gate_r <= G_CONT_HI;
        set_r  <= 1'b1;
        len_r  <= phase_len(h_cfg_r);
      end else begin
        gate_r <= G_STOP;
        set_r  <= 1'b0;
      end
    end else if (commit_s && cmd_r == CMD_TRIG && en_r &&
                 gate_r != G_CONT_HI && gate_r != G_CONT_LO) begin
      gate_r <= G_SHOT;
      set_r  <= 1'b1;
      cnt_r  <= '0;
      len_r  <= phase_len(h_cfg_r);
    end else if (gate_r == G_STOP) begin
      set_r <= 1'b0;
    end else if (cnt_r == len_r - CNT_W'(1)) begin
      cnt_r <= '0;
      case (gate_r)
        G_CONT_HI: begin
          gate_r <= G_CONT_LO;
          set_r  <= 1'b0;
          len_r  <= phase_len(l_cfg_r);
        end
        G_CONT_LO: begin
          gate_r <= G_CONT_HI;
          set_r  <= 1'b1;
          len_r  <= phase_len(h_cfg_r);
        end
        default: begin
          gate_r <= G_STOP;
          set_r  <= 1'b0;
        end
      endcase
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign rx_ready    = rx_ready_r;
  assign up          = up_r;
  assign down        = down_r;
  assign up_states   = up_states_r;
  assign down_states = down_states_r;
  assign idle        = idle_r;
  assign en          = en_r;
  assign set         = set_r;
  assign busy        = busy_r;
  assign cmd_err     = cmd_err_r;
endmodule

// File: tb/tb_dac_seq_loader.sv
// Randomized self-checking bench for dac_seq_loader with a transaction-level reference model.
module tb_dac_seq_loader;
  localparam int DEPTH       = 10;
  localparam int TIMEOUT_CYC = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, en, set, busy, cmd_err;
  logic [79:0] up, down;
  logic [7:0]  up_states, down_states, idle;

  always #5 clk = ~clk;

  dac_seq_loader dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .up(up), .down(down), .up_states(up_states), .down_states(down_states), .idle(idle),
    .en(en), .set(set), .busy(busy), .cmd_err(cmd_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outputs as the command rules define them, plus the gate as a
  // timeline of phases each ending at an absolute cycle number.
  logic [7:0] m_up [DEPTH];
  logic [7:0] m_dn [DEPTH];
  logic [7:0] m_ups, m_dns, m_idle;
  logic [7:0] pl [$];
  int         m_h, m_l, m_need, m_cmd, m_idlecnt, g_mode;
  bit         m_en, m_err, m_ready, m_busy, m_commit, m_inpay, g_hi;
  longint     cyc, g_end;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int plen(input int c);
    case (c)
      1, 2:    plen = DEPTH;
      3:       plen = 3;
      4:       plen = 4;
      5:       plen = 1;
      6:       plen = 0;
      default: plen = -1;
    endcase
  endfunction

  function automatic logic [7:0] clampv(input logic [7:0] v);
    if (v == 8'd0) return 8'd1;
    if (int'(v) > DEPTH) return 8'(DEPTH);
    return v;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) begin m_up[k] = 8'h00; m_dn[k] = 8'h00; end
    m_ups = 8'd1; m_dns = 8'd1; m_idle = 8'h00; m_h = 0; m_l = 0;
    m_en = 1'b0; m_err = 1'b0; m_ready = 1'b1; m_busy = 1'b0; m_commit = 1'b0;
    m_inpay = 1'b0; m_idlecnt = 0; g_mode = 0; g_hi = 1'b0; pl.delete();
  endtask

  task automatic model_step();
    bit acc;
    int act;
    acc = rx_valid && m_ready;
    cyc++;
    m_err = 1'b0;
    act = 0;
    if (m_commit && m_cmd == 5) act = ((pl[0] & 8'h03) == 8'h03) ? 1 : 3;
    else if (m_commit && m_cmd == 6 && m_en && g_mode != 1) act = 2;
    case (act)
      1: begin g_mode = 1; g_hi = 1'b1; g_end = cyc + max1(m_h); end
      2: begin g_mode = 2; g_hi = 1'b1; g_end = cyc + max1(m_h); end
      3: begin g_mode = 0; g_hi = 1'b0; end
      default: begin
        if (g_mode != 0 && cyc == g_end) begin
          if (g_mode == 2) begin g_mode = 0; g_hi = 1'b0; end
          else begin g_hi = !g_hi; g_end = cyc + max1(g_hi ? m_h : m_l); end
        end
      end
    endcase
    if (m_commit) begin
      case (m_cmd)
        1: for (int k = 0; k < DEPTH; k++) m_up[k] = pl[k];
        2: for (int k = 0; k < DEPTH; k++) m_dn[k] = pl[k];
        3: begin m_ups = clampv(pl[0]); m_dns = clampv(pl[1]); m_idle = pl[2]; end
        4: begin m_h = int'(pl[0]) + 256 * int'(pl[1]); m_l = int'(pl[2]) + 256 * int'(pl[3]); end
        5: m_en = pl[0][0];
        default: ;
      endcase
      m_commit = 1'b0;
    end else if (acc && !m_inpay) begin
      m_cmd = int'(rx_data);
      m_need = plen(m_cmd);
      pl.delete();
      if (m_need == 0) m_commit = 1'b1;
      else if (m_need > 0) m_inpay = 1'b1;
      else m_err = 1'b1;
    end else if (acc) begin
      pl.push_back(rx_data);
      m_idlecnt = 0;
      if (pl.size() == m_need) begin m_inpay = 1'b0; m_commit = 1'b1; end
    end else if (m_inpay) begin
`ifdef LOADER_TIMEOUT_EN
      m_idlecnt++;
      if (m_idlecnt == TIMEOUT_CYC) begin m_inpay = 1'b0; m_err = 1'b1; m_idlecnt = 0; end
`endif
    end
    m_ready = !m_commit;
    m_busy  = m_inpay || m_commit;
  endtask

  // Model steps on each rising edge; DUT outputs are compared on the falling edge.
  initial begin
    logic [79:0] eu, ed;
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < DEPTH; k++) begin eu[8*k +: 8] = m_up[k]; ed[8*k +: 8] = m_dn[k]; end
        chk("up", up, eu);
        chk("down", down, ed);
        chk("up_states", 80'(up_states), 80'(m_ups));
        chk("down_states", 80'(down_states), 80'(m_dns));
        chk("idle", 80'(idle), 80'(m_idle));
        chk("en", 80'(en), 80'(m_en));
        chk("set", 80'(set), 80'(g_hi));
        chk("rx_ready", 80'(rx_ready), 80'(m_ready));
        chk("busy", 80'(busy), 80'(m_busy));
        chk("cmd_err", 80'(cmd_err), 80'(m_err));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!m_ready && guard < 20) begin @(negedge clk); guard++; end
    if (guard >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL send_wait: rx_ready never expected high, byte %h", b);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic rand_txn();
    int sel = $urandom_range(0, 9);
    case (sel)
      0, 1: begin
        send_byte(8'($urandom_range(1, 2)));
        for (int i = 0; i < DEPTH; i++) begin
          repeat ($urandom_range(0, 1)) @(negedge clk);
          send_byte(8'($urandom_range(0, 255)));
        end
      end
      2: begin
        send_byte(8'h03);
        send_byte(8'($urandom_range(0, 15)));
        send_byte(8'($urandom_range(0, 15)));
        send_byte(8'($urandom_range(0, 255)));
      end
      3: begin
        send_byte(8'h04);
        send_byte(8'($urandom_range(0, 5))); send_byte(8'h00);
        send_byte(8'($urandom_range(0, 5))); send_byte(8'h00);
      end
      4, 5: begin send_byte(8'h05); send_byte(8'($urandom_range(0, 3))); end
      6, 7: send_byte(8'h06);
      default: send_byte(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(7, 255)));
    endcase
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  int pat_gate [11] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
  int pat_shot [8]  = '{0, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_up", up, 80'h0);
    chk("rst_down", down, 80'h0);
    chk("rst_up_states", 80'(up_states), 80'd1);
    chk("rst_down_states", 80'(down_states), 80'd1);
    chk("rst_en_set", 80'({en, set}), 80'd0);
    chk("rst_rx_ready", 80'(rx_ready), 80'd1);

    send_byte(8'h01);
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(i * 16));
    @(negedge clk);
    chk("commit_ready_low", 80'(rx_ready), 80'd0);
    chk("commit_busy", 80'(busy), 80'd1);
    chk("commit_up_old", up, 80'h0);
    @(negedge clk);
    chk("up_table", up, 80'hA0_90_80_70_60_50_40_30_20_10);
    chk("post_ready", 80'({rx_ready, busy}), 80'b10);

    send_byte(8'h03); send_byte(8'h00); send_byte(8'h0F); send_byte(8'h80);
    repeat (2) @(negedge clk);
    chk("cfg_up_states", 80'(up_states), 80'd1);
    chk("cfg_down_states", 80'(down_states), 80'd10);
    chk("cfg_idle", 80'(idle), 80'h80);

    send_byte(8'h04); send_byte(8'h03); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h03);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk($sformatf("gate_pat%0d", i), 80'(set), 80'(pat_gate[i]));
      if (i == 1) chk("gate_en", 80'(en), 80'd1);
    end

    send_byte(8'h05); send_byte(8'h01);
    send_byte(8'h06);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("shot_pat%0d", i), 80'(set), 80'(pat_shot[i]));
    end

    send_byte(8'h04); send_byte(8'd20); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h06);
    send_byte(8'h05); send_byte(8'h00);
    @(negedge clk);
    chk("stop_commit_set", 80'(set), 80'd1);
    @(negedge clk);
    chk("stop_set", 80'(set), 80'd0);
    chk("stop_en", 80'(en), 80'd0);

    send_byte(8'h7E);
    @(negedge clk);
    chk("err_pulse", 80'(cmd_err), 80'd1);
    @(negedge clk);
    chk("err_clear", 80'({cmd_err, busy}), 80'd0);

`ifdef LOADER_TIMEOUT_EN
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (TIMEOUT_CYC + 5) @(negedge clk);
    chk("timeout_down", down, 80'h0);
    chk("timeout_idle", 80'({busy, rx_ready}), 80'b01);
    send_byte(8'h05); send_byte(8'h00);
`endif

    send_byte(8'h01); send_byte(8'h55); send_byte(8'h66);
    do_reset();
    @(negedge clk);
    chk("midrst_up", up, 80'h0);
    chk("midrst_busy_ready", 80'({busy, rx_ready}), 80'b01);

    for (int t = 0; t < 200; t++) rand_txn();
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
